// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; never below 1 so a counter always has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell reused by the serial adder.
// Purely combinational: one bit of sum and the carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic fsum,
  output logic fcarry
);

  assign fsum   = a ^ b ^ c;
  assign fcarry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin LSB first, one bit per clock,
// framed by a start/busy/done handshake. Result held until the next completion.
//
// state   | meaning
// IDLE    | waiting for start
// ADD     | one operand bit added per cycle
// DONE    | result published for one cycle; start here skips IDLE
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_fsum;
  logic             w_fcarry;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_sh_next;

  full_adder u_fa (
    .a      (r_a[0]),
    .b      (r_b[0]),
    .c      (r_carry),
    .fsum   (w_fsum),
    .fcarry (w_fcarry)
  );

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sh_next = {w_fsum, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_ADD;
      end
      ST_ADD: begin
        busy = 1'b1;
        if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = start ? ST_ADD : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == ST_ADD) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sh    <= w_sh_next;
      r_carry <= w_fcarry;
      r_cnt   <= r_cnt + CW'(1);
      // On the MSB edge r_carry is the carry into the MSB, so ovf needs no extra latch.
      if (w_last) begin
        sum  <= w_sh_next;
        cout <= w_fcarry;
        ovf  <= r_carry ^ w_fcarry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: table of WIDTH=8 vectors, multi-cycle
// handshake corner cases, and an exhaustive WIDTH=2 sweep on a second instance.
module tb_serial_adder;

  localparam int HALF_PERIOD = 5;
  localparam int MAX_WAIT    = 40;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int n_tests;
  int n_fail;
  int n_overlap;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #HALF_PERIOD clk = ~clk;

  always @(negedge clk) begin
    if ((done8 && busy8) || (done2 && busy2)) n_overlap++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called one step after the accepting edge; samples just after each later edge.
  task automatic wait_done8(input int pulse_at, output int bcnt, output bit seen);
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) bcnt++;
        if (i == pulse_at) begin
          start8 = 1'b1;
          a8     = 8'hFF;
        end
        @(posedge clk); #1;
        start8 = 1'b0;
      end
    end
  endtask

  task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  initial begin
    int  bcnt;
    bit  seen;
    int  dcnt;
    bit  held;
    logic [2:0] exp3;
    logic       exp_ov2;

    n_tests = 0; n_fail = 0; n_overlap = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_sum",  64'(sum8),  64'd0);
    check("reset_cout", 64'(cout8), 64'd0);
    check("reset_ovf",  64'(ovf8),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      launch8(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done8(-1, bcnt, seen);
      check($sformatf("vec%0d_done_seen", i), 64'(seen), 64'd1);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd8);
      check($sformatf("vec%0d_sum", i),  64'(sum8),  64'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 64'(cout8), 64'(vecs[i].co));
      check($sformatf("vec%0d_ovf", i),  64'(ovf8),  64'(vecs[i].ov));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_single", i), 64'(done8), 64'd0);
    end

    // start pulsed mid-ADD must not disturb the operation in flight
    launch8(8'h12, 8'h34, 1'b0);
    wait_done8(3, bcnt, seen);
    check("ign_done_seen", 64'(seen), 64'd1);
    check("ign_busy_cycles", 64'(bcnt), 64'd8);
    check("ign_sum", 64'(sum8), 64'h46);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    check("ign_extra_done", 64'(dcnt), 64'd0);

    // start held through DONE: back-to-back with no IDLE bubble
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    bcnt = 0; seen = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) bcnt++;
        @(posedge clk); #1;
      end
    end
    check("b2b_first_done", 64'(seen), 64'd1);
    check("b2b_first_sum", 64'(sum8), 64'h10);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_no_idle_busy", 64'(busy8), 64'd1);
    held = 1'b1;
    bcnt = 0; seen = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) bcnt++;
        if (sum8 !== 8'h10) held = 1'b0;
        @(posedge clk); #1;
      end
    end
    check("b2b_hold_first", 64'(held), 64'd1);
    check("b2b_second_busy", 64'(bcnt), 64'd8);
    check("b2b_second_sum", 64'(sum8), 64'h00);
    check("b2b_second_cout", 64'(cout8), 64'd1);
    check("b2b_second_ovf", 64'(ovf8), 64'd1);
    @(posedge clk); #1;

    // reset asserted at cnt=4 aborts asynchronously
    launch8(8'h0F, 8'h01, 1'b0);
    wait_done8(-1, bcnt, seen);
    check("rst_pre_sum", 64'(sum8), 64'h10);
    @(posedge clk); #1;
    launch8(8'h55, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum",  64'(sum8),  64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_ovf",  64'(ovf8),  64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcnt++;
    end
    check("rst_no_done", 64'(dcnt), 64'd0);
    launch8(8'h55, 8'h22, 1'b1);
    wait_done8(-1, bcnt, seen);
    check("rst_after_seen", 64'(seen), 64'd1);
    check("rst_after_sum", 64'(sum8), 64'h78);
    check("rst_after_cout", 64'(cout8), 64'd0);
    @(posedge clk); #1;

    // WIDTH=2: every {a, b, cin}
    for (int va = 0; va < 4; va++) begin
      for (int vb = 0; vb < 4; vb++) begin
        for (int vc = 0; vc < 2; vc++) begin
          int nf0;
          nf0 = n_fail;
          a2 = 2'(va); b2 = 2'(vb); cin2 = 1'(vc); start2 = 1'b1;
          @(posedge clk); #1;
          start2 = 1'b0;
          seen = 1'b0;
          for (int i = 0; i < MAX_WAIT && !seen; i++) begin
            if (done2) seen = 1'b1;
            else begin
              @(posedge clk); #1;
            end
          end
          exp3    = 3'(va + vb + vc);
          exp_ov2 = (a2[1] == b2[1]) && (exp3[1] != a2[1]);
          check($sformatf("w2_seen_%0d_%0d_%0d", va, vb, vc), 64'(seen), 64'd1);
          check($sformatf("w2_sum_%0d_%0d_%0d", va, vb, vc), 64'({cout2, sum2}), 64'(exp3));
          check($sformatf("w2_ovf_%0d_%0d_%0d", va, vb, vc), 64'(ovf2), 64'(exp_ov2));
          if (n_fail == nf0) $display("PASS w2 a=%0d b=%0d cin=%0d", va, vb, vc);
          @(posedge clk); #1;
        end
      end
    end

    check("done_busy_overlap", 64'(n_overlap), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
